// File: rtl/aik_digit_accum.sv
// Collects NUM_DIGITS decoded decimal digits (most significant digit first) into one
// unsigned binary value. The result is offered on a valid/ready handshake with a sticky bad-digit flag.
module aik_digit_accum #(
  parameter int NUM_DIGITS = 4,
  parameter int OUT_W      = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             digit_valid,
  output logic             digit_ready,
  input  logic [3:0]       digit_bin,
  input  logic             digit_invalid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] value,
  output logic             err,
  output logic             busy
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [OUT_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_nxt;
  logic             accept;
  logic             bad;
  logic [OUT_W-1:0] contrib;

  // Every output is decoded from state or taken straight from a register.
  assign digit_ready = (state == ACCUM);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign value       = acc;

  assign accept  = digit_valid & digit_ready;
  assign bad     = digit_invalid | (digit_bin > 4'd9);
  assign contrib = bad ? '0 : OUT_W'(digit_bin);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      ACCUM: begin
        if (accept) begin
          // acc*10 as shift-and-add; a contribution of at most 9 cannot overflow OUT_W.
          acc_nxt = (acc << 3) + (acc << 1) + contrib;
          cnt_nxt = cnt + 1'b1;
          if (bad) begin
            err_nxt = 1'b1;
          end
          if (cnt == LAST_CNT) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          if (start) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aik_digit_accum.sv
// Randomized self-checking bench for aik_digit_accum.
// Expected results come from a positional-weight decimal model of each frame.
module tb_aik_digit_accum;

  localparam int N = 4;
  localparam int W = 14;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         digit_valid;
  logic         digit_ready;
  logic [3:0]   digit_bin;
  logic         digit_invalid;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] value;
  logic         err;
  logic         busy;

  int vectors;
  int miscompares;

  logic [3:0]   fr_d   [N];
  logic         fr_inv [N];
  logic [W-1:0] exp_value;
  logic         exp_err;

  aik_digit_accum #(.NUM_DIGITS(N), .OUT_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .digit_valid  (digit_valid),
    .digit_ready  (digit_ready),
    .digit_bin    (digit_bin),
    .digit_invalid(digit_invalid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .value        (value),
    .err          (err),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: value is the sum of good digits times their decimal place weight.
  task automatic compute_expected();
    int total;
    int weight;
    total   = 0;
    exp_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      weight = 1;
      for (int k = 0; k < N - 1 - i; k++) weight = weight * 10;
      if (fr_inv[i] || fr_d[i] > 4'd9) exp_err = 1'b1;
      else total = total + int'(fr_d[i]) * weight;
    end
    exp_value = W'(total);
  endtask

  task automatic set_frame(input int d0, input int d1, input int d2, input int d3,
                           input bit i0, input bit i1, input bit i2, input bit i3);
    fr_d[0] = 4'(d0); fr_d[1] = 4'(d1); fr_d[2] = 4'(d2); fr_d[3] = 4'(d3);
    fr_inv[0] = i0; fr_inv[1] = i1; fr_inv[2] = i2; fr_inv[3] = i3;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_frame(input int mingap, input int maxgap, input bit pulse_start);
    int gap;
    compute_expected();
    for (int i = 0; i < N; i++) begin
      digit_valid   = 1'b1;
      digit_bin     = fr_d[i];
      digit_invalid = fr_inv[i];
      tick();
      digit_valid   = 1'b0;
      digit_bin     = 4'($urandom_range(0, 15));
      digit_invalid = 1'($urandom_range(0, 1));
      if (i < N - 1) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL early_valid digit %0d: got %b expected 0", i, out_valid);
        end
        gap = (maxgap > 0) ? int'($urandom_range(mingap, maxgap)) : 0;
        repeat (gap) begin
          start = pulse_start ? 1'($urandom_range(0, 1)) : 1'b0;
          tick();
        end
        start = 1'b0;
      end
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL done_valid: got %b expected 1", out_valid);
    end
    vectors++;
    if (value !== exp_value) begin
      miscompares++;
      $display("[TB] FAIL value: got %0d expected %0d", value, exp_value);
    end
    vectors++;
    if (err !== exp_err) begin
      miscompares++;
      $display("[TB] FAIL err: got %b expected %b", err, exp_err);
    end
    vectors++;
    if (digit_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL done_ready: got %b expected 0", digit_ready);
    end
  endtask

  // Hold DONE under backpressure, then release it, either back to IDLE or straight into a new frame.
  task automatic finish_frame(input int hold, input bit b2b);
    out_ready = 1'b0;
    repeat (hold) begin
      digit_valid = 1'($urandom_range(0, 1));
      digit_bin   = 4'($urandom_range(0, 9));
      start       = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (out_valid !== 1'b1 || value !== exp_value || err !== exp_err || digit_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold: got valid=%b value=%0d err=%b ready=%b expected 1/%0d/%b/0",
                 out_valid, value, err, digit_ready, exp_value, exp_err);
      end
    end
    digit_valid = 1'b0;
    out_ready   = 1'b1;
    start       = b2b;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== b2b || digit_ready !== b2b) begin
      miscompares++;
      $display("[TB] FAIL release: got valid=%b busy=%b ready=%b expected 0/%b/%b",
               out_valid, busy, digit_ready, b2b, b2b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    vectors++;
    if ({out_valid, digit_ready, busy, err} !== 4'b0000 || value !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset: got valid=%b ready=%b busy=%b err=%b value=%0d expected all 0",
               out_valid, digit_ready, busy, err, value);
    end
    digit_valid = 1'b1;
    digit_bin   = 4'd7;
    repeat (3) tick();
    digit_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0 || digit_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_ignore: got busy=%b ready=%b expected 0/0", busy, digit_ready);
    end
  endtask

  task automatic test_nominal();
    start_frame();
    vectors++;
    if (busy !== 1'b1 || digit_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL accum_entry: got busy=%b ready=%b expected 1/1", busy, digit_ready);
    end
    set_frame(1, 2, 3, 4, 0, 0, 0, 0);
    drive_frame(0, 0, 0);
    finish_frame(0, 0);
  endtask

  task automatic test_bad_digit();
    start_frame();
    set_frame(9, 15, 9, 9, 0, 1, 0, 0);
    drive_frame(0, 0, 0);
    finish_frame(0, 0);
    start_frame();
    set_frame(9, 12, 9, 9, 0, 0, 0, 0);
    drive_frame(0, 0, 0);
    finish_frame(0, 0);
  endtask

  task automatic test_backpressure();
    start_frame();
    set_frame(9, 9, 9, 9, 0, 0, 0, 0);
    drive_frame(0, 0, 0);
    finish_frame(5, 0);
  endtask

  task automatic test_gapped();
    start_frame();
    set_frame(0, 5, 0, 3, 0, 0, 0, 0);
    drive_frame(1, 3, 1);
    finish_frame(0, 0);
  endtask

  task automatic test_reset_midframe();
    start_frame();
    for (int i = 0; i < 2; i++) begin
      digit_valid = 1'b1;
      digit_bin   = 4'd8;
      tick();
    end
    digit_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if ({out_valid, digit_ready, busy, err} !== 4'b0000 || value !== '0) begin
      miscompares++;
      $display("[TB] FAIL midframe_reset: got valid=%b ready=%b busy=%b err=%b value=%0d expected all 0",
               out_valid, digit_ready, busy, err, value);
    end
    start_frame();
    set_frame(0, 0, 0, 7, 0, 0, 0, 0);
    drive_frame(0, 0, 0);
    finish_frame(0, 0);
  endtask

  task automatic test_back_to_back();
    start_frame();
    set_frame(1, 10, 2, 3, 0, 0, 0, 0);
    drive_frame(0, 0, 0);
    finish_frame(0, 1);
    set_frame(5, 6, 7, 8, 0, 0, 0, 0);
    drive_frame(0, 0, 0);
    finish_frame(0, 0);
  endtask

  task automatic test_random();
    bit in_accum;
    bit b2b;
    in_accum = 1'b0;
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < N; i++) begin
        fr_d[i]   = 4'($urandom_range(0, 15));
        fr_inv[i] = ($urandom_range(0, 7) == 0);
      end
      if (!in_accum) start_frame();
      drive_frame(0, 2, 1);
      b2b = 1'($urandom_range(0, 1));
      finish_frame(int'($urandom_range(0, 3)), b2b);
      in_accum = b2b;
    end
    if (in_accum) begin
      for (int i = 0; i < N; i++) begin
        fr_d[i]   = 4'($urandom_range(0, 9));
        fr_inv[i] = 1'b0;
      end
      drive_frame(0, 0, 0);
      finish_frame(0, 0);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    start         = 1'b0;
    digit_valid   = 1'b0;
    digit_bin     = 4'd0;
    digit_invalid = 1'b0;
    out_ready     = 1'b0;
    test_reset();
    test_nominal();
    test_bad_digit();
    test_backpressure();
    test_gapped();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aik_digit_accum.md
Name: aik_digit_accum

Overview:
- Downstream consumer of the Aiken-to-binary converter stage.
- Collects a stream of decoded decimal digits (4-bit binary plus invalid flag), most significant digit first.
- Accumulates NUM_DIGITS digits into one unsigned binary value and presents it on a valid/ready output handshake.
- Flags any invalid or out-of-range digit in the frame.

Parameters:
- NUM_DIGITS, 4, number of decimal digits per frame; minimum 1.
- OUT_W, 14, result width; must be at least ceil(log2(10^NUM_DIGITS)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a new frame; sampled only as listed in Behaviour.
- digit_valid  input  1  a digit is presented.
- digit_ready  output  1  block accepts a digit this cycle.
- digit_bin  input  4  decoded digit from the converter.
- digit_invalid  input  1  converter invalid flag for digit_bin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- value  output  OUT_W  accumulated binary result.
- err  output  1  frame contained at least one bad digit; qualified by out_valid.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - acc, digit count, err, value, out_valid, digit_ready and busy all go to 0.
  - Reset applies in any state, including mid-frame; the partial frame is discarded and no output is produced for it.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - digit_ready=0, out_valid=0.
  - start=1 -> ACCUM, with acc=0, cnt=0, err=0.
  - digit_valid is ignored.
- ACCUM:
  - digit_ready=1.
  - Accept = digit_valid & digit_ready.
  - On accept:
    - A digit is bad when digit_invalid=1 or digit_bin>9.
    - A bad digit contributes 0 and sets err (sticky until the next start).
    - acc <= acc*10 + d, where d = digit_bin if good, else 0.
    - cnt <= cnt+1.
  - When the accepted digit is digit number NUM_DIGITS (cnt == NUM_DIGITS-1) -> DONE.
  - Idle cycles (digit_valid=0) hold acc and cnt indefinitely.
  - start is ignored in ACCUM.
- DONE:
  - out_valid=1, value=acc, err as accumulated; digit_ready=0.
  - value and err are stable while out_valid=1 and out_ready=0.
  - out_ready=1 and start=0 -> IDLE.
  - out_ready=1 and start=1 in the same cycle -> ACCUM directly, clearing acc, cnt and err.
  - start with out_ready=0 is ignored.
- Latency: out_valid rises on the clock edge that accepts the last digit, i.e. it is visible the cycle after that accept.
- Throughput: NUM_DIGITS accepts plus 1 DONE cycle per frame with back-to-back start.
- Arithmetic:
  - acc*10 is computed as (acc<<3)+(acc<<1) in OUT_W bits.
  - Every contribution is at most 9, so no overflow occurs under the OUT_W rule.
  - Maximum result is 10^NUM_DIGITS - 1.
- value outside DONE: holds the last acc; consumers qualify it with out_valid.

Test Plan:
1. Nominal frame: start, then digits 1,2,3,4 on consecutive cycles with invalid=0, out_ready=1 -> value=1234 (0x4D2), err=0, out_valid high exactly 1 cycle after the 4th accept, then IDLE.
2. Bad digit: start; digits 9, (digit_bin=0xF, digit_invalid=1), 9, 9 -> value=9099, err=1. Repeat with digit_bin=0xC, digit_invalid=0 in slot 2 -> value=9099, err=1.
3. Backpressure: frame 9,9,9,9 with out_ready low for 5 cycles -> out_valid held, value=9999 (0x270F) stable, digit_ready=0. Extra digit_valid pulses during DONE are not consumed.
4. Gapped input: digits 0,5,0,3 with digit_valid low 1-3 cycles between each -> value=503, err=0. start pulses during ACCUM are ignored.
5. Reset mid-frame: after 2 digits accepted, drive rst_n=0 for 1 cycle -> all outputs 0, state IDLE. A new frame 0,0,0,7 -> value=7, err=0, with no residue from the aborted frame.
6. Back-to-back frames: in DONE, assert out_ready=1 and start=1 together -> next cycle busy=1, digit_ready=1. Next frame 5,6,7,8 -> value=5678, err cleared to 0 even though the prior frame had err=1.
